// File: rtl/uart_pkt_pkg.sv
// Shared types and constants for the UART packet framing stage.
package uart_pkt_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StLen,
    StPayload,
    StChk,
    StSend
  } state_e;

  localparam logic [1:0] ERR_OVERRUN = 2'd0;
  localparam logic [1:0] ERR_BAD_LEN = 2'd1;
  localparam logic [1:0] ERR_BAD_CHK = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT = 2'd3;

  localparam logic [7:0] DEFAULT_SOF_BYTE = 8'hA5;

endpackage

// File: rtl/uart_pkt_buf.sv
// Payload buffer: synchronous write, combinational read, deliberately not reset.
module uart_pkt_buf #(
  parameter int unsigned Depth = 16,
  parameter int unsigned AddrW = 4
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [AddrW-1:0] waddr_i,
  input  logic [7:0]       wdata_i,
  input  logic [AddrW-1:0] raddr_i,
  output logic [7:0]       rdata_o
);

  logic [7:0] mem_q [Depth];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/uart_pkt_parser.sv
// Frames SOF/LEN/payload/CHK byte strobes, checks the XOR checksum and replays
// good payloads on a valid/ready stream; bad frames raise err_pulse/err_code.
module uart_pkt_parser
  import uart_pkt_pkg::*;
#(
  parameter int unsigned MAX_LEN       = 16,
  parameter logic [7:0]  SOF_BYTE      = DEFAULT_SOF_BYTE,
  parameter int unsigned TIMEOUT_TICKS = 27000
) (
  input  logic       clock,
  input  logic       n_reset,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       out_last,
  output logic [7:0] pkt_len,
  output logic       busy,
  output logic       err_pulse,
  output logic [1:0] err_code
);

  localparam int unsigned IdxW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int unsigned TmoW = $clog2(TIMEOUT_TICKS + 1);
  // Terminal cycle is the (TIMEOUT_TICKS-1)th idle cycle after the last byte.
  localparam logic [TmoW-1:0] TmoTerm = (TIMEOUT_TICKS > 1) ? TmoW'(TIMEOUT_TICKS - 2) : '0;
  localparam logic [7:0] MaxLen = 8'(MAX_LEN);

  state_e            state_q, state_d;
  logic [7:0]        len_q, len_d;
  logic [7:0]        chk_q, chk_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic [IdxW-1:0]   rd_idx_q, rd_idx_d;
  logic [TmoW-1:0]   tmo_q, tmo_d;
  logic              out_valid_q, out_valid_d;
  logic              err_pulse_q, err_pulse_d;
  logic [1:0]        err_code_q, err_code_d;
  logic              buf_we;
  logic [7:0]        buf_rdata;
  logic              in_frame;
  logic              tmo_hit;
  logic              wr_last;
  logic              rd_last;

  uart_pkt_buf #(
    .Depth (MAX_LEN),
    .AddrW (IdxW)
  ) u_buf (
    .clk_i   (clock),
    .we_i    (buf_we),
    .waddr_i (idx_q),
    .wdata_i (in_data),
    .raddr_i (rd_idx_q),
    .rdata_o (buf_rdata)
  );

  assign in_frame = (state_q == StLen) || (state_q == StPayload) || (state_q == StChk);
  assign tmo_hit  = in_frame && !in_valid && (tmo_q == TmoTerm);
  // Compare in 8 bits so a length of MAX_LEN never wraps the narrower index.
  assign wr_last  = (8'(idx_q) == len_q - 8'd1);
  assign rd_last  = (8'(rd_idx_q) == len_q - 8'd1);

  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    chk_d       = chk_q;
    idx_d       = idx_q;
    rd_idx_d    = rd_idx_q;
    tmo_d       = tmo_q;
    out_valid_d = out_valid_q;
    err_pulse_d = 1'b0;
    err_code_d  = err_code_q;
    buf_we      = 1'b0;

    if (in_frame) begin
      tmo_d = in_valid ? '0 : tmo_q + TmoW'(1);
    end

    unique case (state_q)
      StIdle: begin
        tmo_d = '0;
        if (in_valid && (in_data == SOF_BYTE)) begin
          state_d = StLen;
        end
      end
      StLen: begin
        if (in_valid) begin
          if ((in_data == 8'd0) || (in_data > MaxLen)) begin
            state_d     = StIdle;
            err_pulse_d = 1'b1;
            err_code_d  = ERR_BAD_LEN;
          end else begin
            len_d   = in_data;
            chk_d   = in_data;
            idx_d   = '0;
            state_d = StPayload;
          end
        end
      end
      StPayload: begin
        if (in_valid) begin
          buf_we = 1'b1;
          chk_d  = chk_q ^ in_data;
          if (wr_last) begin
            state_d = StChk;
          end else begin
            idx_d = idx_q + IdxW'(1);
          end
        end
      end
      StChk: begin
        if (in_valid) begin
          if (in_data == chk_q) begin
            state_d     = StSend;
            rd_idx_d    = '0;
            out_valid_d = 1'b1;
          end else begin
            state_d     = StIdle;
            err_pulse_d = 1'b1;
            err_code_d  = ERR_BAD_CHK;
          end
        end
      end
      StSend: begin
        if (in_valid) begin
          err_pulse_d = 1'b1;
          err_code_d  = ERR_OVERRUN;
        end
        if (out_valid_q && out_ready) begin
          if (rd_last) begin
            out_valid_d = 1'b0;
            state_d     = StIdle;
          end else begin
            rd_idx_d = rd_idx_q + IdxW'(1);
          end
        end
      end
      default: state_d = StIdle;
    endcase

    if (tmo_hit) begin
      state_d     = StIdle;
      err_pulse_d = 1'b1;
      err_code_d  = ERR_TIMEOUT;
    end
  end

  always_ff @(posedge clock or negedge n_reset) begin
    if (!n_reset) begin
      state_q     <= StIdle;
      len_q       <= '0;
      chk_q       <= '0;
      idx_q       <= '0;
      rd_idx_q    <= '0;
      tmo_q       <= '0;
      out_valid_q <= 1'b0;
      err_pulse_q <= 1'b0;
      err_code_q  <= '0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      chk_q       <= chk_d;
      idx_q       <= idx_d;
      rd_idx_q    <= rd_idx_d;
      tmo_q       <= tmo_d;
      out_valid_q <= out_valid_d;
      err_pulse_q <= err_pulse_d;
      err_code_q  <= err_code_d;
    end
  end

  // Gate the unreset buffer read so outputs read 0 outside a replay.
  assign out_valid = out_valid_q;
  assign out_data  = out_valid_q ? buf_rdata : 8'h00;
  assign out_last  = out_valid_q && rd_last;
  assign pkt_len   = out_valid_q ? len_q : 8'h00;
  assign busy      = (state_q != StIdle);
  assign err_pulse = err_pulse_q;
  assign err_code  = err_code_q;

endmodule

// File: tb/tb_uart_pkt_parser.sv
// Self-checking bench for uart_pkt_parser: directed frames plus random frames
// scored against a frame-level reference model.
module tb_uart_pkt_parser;

  localparam int unsigned MAX_LEN = 16;
  localparam int unsigned T       = 40;
  localparam logic [7:0]  SOF     = 8'hA5;

  typedef logic [7:0] bq_t[$];

  logic       clock;
  logic       n_reset;
  logic [7:0] in_data;
  logic       in_valid;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       out_last;
  logic [7:0] pkt_len;
  logic       busy;
  logic       err_pulse;
  logic [1:0] err_code;

  uart_pkt_parser #(
    .MAX_LEN       (MAX_LEN),
    .SOF_BYTE      (SOF),
    .TIMEOUT_TICKS (T)
  ) dut (
    .clock     (clock),
    .n_reset   (n_reset),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last),
    .pkt_len   (pkt_len),
    .busy      (busy),
    .err_pulse (err_pulse),
    .err_code  (err_code)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_bad = 0;
  int ready_mode = 0;  // 0 high, 1 random, 2 low, 3 toggle, 4 manual

  logic [16:0] exp_out[$];
  logic [16:0] got_out[$];
  logic [1:0]  exp_err[$];
  logic [1:0]  got_err[$];
  logic        prev_stall = 1'b0;
  logic [16:0] prev_item = '0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Monitor: collects transfers and error events, checks hold stability.
  always @(negedge clock) begin
    if (prev_stall && n_reset) begin
      check_eq("hold_valid", 32'(out_valid), 32'd1);
      check_eq("hold_item", 32'({out_last, pkt_len, out_data}), 32'(prev_item));
    end
    if (out_valid && out_ready) got_out.push_back({out_last, pkt_len, out_data});
    if (err_pulse) got_err.push_back(err_code);
    prev_stall <= n_reset && out_valid && !out_ready;
    prev_item  <= {out_last, pkt_len, out_data};
  end

  always @(posedge clock) begin
    #1;
    case (ready_mode)
      0: out_ready = 1'b1;
      1: out_ready = 1'($urandom_range(0, 1));
      2: out_ready = 1'b0;
      3: out_ready = ~out_ready;
      default: ;
    endcase
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    in_data  = b;
    in_valid = 1'b1;
    @(posedge clock);
    #1;
    in_valid = 1'b0;
    in_data  = 8'h00;
  endtask

  task automatic send_frame(input bq_t fb, input int maxgap);
    foreach (fb[i]) begin
      send_byte(fb[i]);
      if (maxgap > 0) idle($urandom_range(0, maxgap));
    end
  endtask

  // Reference: what a complete frame starting with SOF must produce.
  task automatic model_frame(input bq_t fb);
    int unsigned len;
    logic [7:0]  x;
    if (fb.size() < 2) return;
    len = fb[1];
    if (len == 0 || len > MAX_LEN) begin
      exp_err.push_back(2'd1);
      return;
    end
    x = fb[1];
    for (int i = 0; i < int'(len); i++) x = x ^ fb[2 + i];
    if (fb[2 + len] != x) begin
      exp_err.push_back(2'd2);
      return;
    end
    for (int i = 0; i < int'(len); i++)
      exp_out.push_back({(i == int'(len) - 1), fb[1], fb[2 + i]});
  endtask

  task automatic compare_scoreboard(input string tag);
    check_eq({tag, "_nout"}, 32'(got_out.size()), 32'(exp_out.size()));
    for (int i = 0; i < exp_out.size() && i < got_out.size(); i++)
      check_eq({tag, "_item"}, 32'(got_out[i]), 32'(exp_out[i]));
    check_eq({tag, "_nerr"}, 32'(got_err.size()), 32'(exp_err.size()));
    for (int i = 0; i < exp_err.size() && i < got_err.size(); i++)
      check_eq({tag, "_code"}, 32'(got_err[i]), 32'(exp_err[i]));
    exp_out.delete();
    got_out.delete();
    exp_err.delete();
    got_err.delete();
  endtask

  task automatic drain(input string tag);
    int k = 0;
    while ((busy || out_valid) && k < 3000) begin
      idle(1);
      k++;
    end
    if (k >= 3000) check_eq({tag, "_drain"}, 32'(busy), 32'd0);
    idle(3);
    compare_scoreboard(tag);
  endtask

  task automatic wait_ov(input string tag);
    int k = 0;
    while (!out_valid && k < 200) begin
      idle(1);
      k++;
    end
    if (!out_valid) check_eq({tag, "_wait"}, 32'(out_valid), 32'd1);
  endtask

  task automatic run_frame(input string tag, input bq_t fb, input int maxgap);
    model_frame(fb);
    send_frame(fb, maxgap);
    drain(tag);
  endtask

  initial begin
    bq_t         fb;
    int          edges;
    int unsigned len;
    logic [7:0]  x;
    logic [7:0]  b;

    n_reset   = 1'b0;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    out_ready = 1'b0;
    idle(3);
    check_eq("rst_out_valid", 32'(out_valid), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_err_pulse", 32'(err_pulse), 32'd0);
    check_eq("rst_err_code", 32'(err_code), 32'd0);
    check_eq("rst_out_last", 32'(out_last), 32'd0);
    check_eq("rst_pkt_len", 32'(pkt_len), 32'd0);
    check_eq("rst_out_data", 32'(out_data), 32'd0);
    n_reset = 1'b1;
    idle(2);

    send_byte(8'h00);
    idle(2);
    check_eq("zero_ignored", 32'(busy), 32'd0);
    compare_scoreboard("zero");

    // Good frame; out_valid must be up the cycle after CHK is taken.
    fb = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h03};
    model_frame(fb);
    send_frame(fb, 0);
    check_eq("ov_rise", 32'(out_valid), 32'd1);
    drain("good");

    fb = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h04};
    run_frame("badchk", fb, 0);
    fb = '{8'hA5, 8'h02, 8'h5A, 8'h6B, 8'h33};
    run_frame("after_bad", fb, 1);

    fb = '{8'hA5, 8'h00};
    run_frame("len0", fb, 0);
    fb = '{8'hA5, 8'h11, 8'h11, 8'h22, 8'h33};
    run_frame("len17", fb, 0);

    // Timeout: error loaded on the (T-1)th edge after the last byte's edge.
    fb = '{8'hA5, 8'h02, 8'h11};
    send_frame(fb, 0);
    exp_err.push_back(2'd3);
    edges = 0;
    while (!err_pulse && edges < 3 * T) begin
      @(posedge clock);
      edges++;
      #1;
    end
    check_eq("tmo_edges", 32'(edges), 32'(T - 1));
    check_eq("tmo_idle", 32'(busy), 32'd0);
    drain("tmo");

    // A byte on the terminal cycle keeps the frame alive.
    fb = '{8'hA5, 8'h02, 8'h11, 8'h22, 8'h31};
    model_frame(fb);
    send_byte(8'hA5);
    send_byte(8'h02);
    send_byte(8'h11);
    idle(T - 2);
    send_byte(8'h22);
    send_byte(8'h31);
    drain("alive");

    // Max length, all payload bytes equal to SOF, stalled then toggled ready.
    ready_mode = 2;
    fb = '{8'hA5, 8'h10};
    for (int i = 0; i < 16; i++) fb.push_back(8'hA5);
    fb.push_back(8'h10);
    model_frame(fb);
    send_frame(fb, 0);
    wait_ov("maxlen");
    idle(5);
    check_eq("stall_no_xfer", 32'(got_out.size()), 32'd0);
    send_byte(8'h5A);
    exp_err.push_back(2'd0);
    ready_mode = 3;
    drain("maxlen");

    // New SOF accepted the cycle right after the final transfer.
    ready_mode = 4;
    out_ready  = 1'b0;
    fb = '{8'hA5, 8'h01, 8'h77, 8'h76};
    model_frame(fb);
    send_frame(fb, 0);
    wait_ov("b2b");
    out_ready = 1'b1;
    idle(1);
    fb = '{8'hA5, 8'h01, 8'h42, 8'h43};
    model_frame(fb);
    send_frame(fb, 0);
    drain("b2b");

    // Reset during replay after two transfers.
    out_ready = 1'b0;
    fb = '{8'hA5, 8'h04, 8'h01, 8'h02, 8'h03, 8'h04, 8'h00};
    send_frame(fb, 0);
    wait_ov("rst");
    out_ready = 1'b1;
    idle(2);
    out_ready = 1'b0;
    #2;
    n_reset = 1'b0;
    #1;
    check_eq("rst_mid_ov", 32'(out_valid), 32'd0);
    check_eq("rst_mid_busy", 32'(busy), 32'd0);
    exp_out.push_back({1'b0, 8'h04, 8'h01});
    exp_out.push_back({1'b0, 8'h04, 8'h02});
    idle(2);
    n_reset = 1'b1;
    idle(1);
    compare_scoreboard("rst");
    ready_mode = 0;
    fb = '{8'hA5, 8'h02, 8'hAB, 8'hCD, 8'h64};
    run_frame("post_rst", fb, 0);

    // Random frames: good, bad checksum, bad length with noise.
    for (int n = 0; n < 40; n++) begin
      ready_mode = $urandom_range(0, 1);
      fb = {};
      fb.push_back(SOF);
      if ($urandom_range(0, 9) < 2) begin
        len = $urandom_range(0, 1) ? 0 : $urandom_range(MAX_LEN + 1, 255);
        fb.push_back(8'(len));
        repeat ($urandom_range(0, 3)) begin
          b = 8'($urandom_range(0, 255));
          fb.push_back((b == SOF) ? 8'h00 : b);
        end
      end else begin
        len = $urandom_range(1, MAX_LEN);
        x = 8'(len);
        fb.push_back(x);
        for (int i = 0; i < int'(len); i++) begin
          b = 8'($urandom_range(0, 255));
          fb.push_back(b);
          x = x ^ b;
        end
        if ($urandom_range(0, 9) < 2) x = x ^ 8'($urandom_range(1, 255));
        fb.push_back(x);
      end
      run_frame("rand", fb, 3);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
